// File: rtl/pulse_xfer_arbiter_pkg.sv
// pulse_xfer_arbiter_pkg
// Shared definitions for the pulse-crossing arbiter slice: FSM state
// encoding, default sizing parameters and the fixed xfer_id width.
package pulse_xfer_arbiter_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int TIMEOUT_DEF = 15;
  localparam int ID_W        = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/pulse_xfer_arbiter_rr_select.sv
// rr_select
// Combinational round-robin pick over the pending vector.
// Ports:
//   pending : request bits waiting for service
//   rr_ptr  : index searched first
//   valid   : at least one pending bit is set
//   index   : first pending index in order rr_ptr, rr_ptr+1, ... mod N_REQ
module rr_select
  import pulse_xfer_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  // Scan from the farthest offset back toward rr_ptr so the nearest hit wins.
  always_comb begin
    int cand;
    valid = 1'b0;
    index = '0;
    cand  = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr) + k) % N_REQ;
      if (pending[IDX_W'(cand)]) begin
        valid = 1'b1;
        index = IDX_W'(cand);
      end else begin
        valid = valid;
        index = index;
      end
    end
  end

endmodule

// File: rtl/pulse_xfer_arbiter.sv
// pulse_xfer_arbiter
// Shares one pulse-crossing channel between N_REQ requesters. Requests are
// collected into pending bits, served round-robin one at a time: issue a
// pulse, wait for the channel busy flag to rise (bounded by TIMEOUT), then
// wait for it to fall and report completion to the served requester.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   req_pulse   : one-cycle request per requester
//   clr_err     : clears sticky overflow/timeout
//   xfer_busy   : channel in-flight flag
//   xfer_pulse  : one-cycle pulse into the channel
//   xfer_id     : requester being served
//   grant_done  : one-cycle completion per requester
//   pending     : queued request bits
//   overflow    : sticky, request hit an already pending bit
//   timeout     : sticky, busy never rose after a pulse
module pulse_xfer_arbiter
  import pulse_xfer_arbiter_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_pulse,
  input  logic             clr_err,
  input  logic             xfer_busy,
  output logic             xfer_pulse,
  output logic [ID_W-1:0]  xfer_id,
  output logic [N_REQ-1:0] grant_done,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] overflow,
  output logic             timeout
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_r, state_s;
  logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_s;
  logic [N_REQ-1:0]   pending_r, pending_s;
  logic [N_REQ-1:0]   overflow_r, overflow_s;
  logic               timeout_r, timeout_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [ID_W-1:0]    xfer_id_r, xfer_id_s;
  logic               xfer_pulse_r, xfer_pulse_s;
  logic [N_REQ-1:0]   grant_done_r, grant_done_s;
  logic [N_REQ-1:0]   clr_mask_s;
  logic               tmo_set_s;
  logic               sel_valid_s;
  logic [IDX_W-1:0]   sel_idx_s;

  rr_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .pending (pending_r),
    .rr_ptr  (rr_ptr_r),
    .valid   (sel_valid_s),
    .index   (sel_idx_s)
  );

  // Next-state and next-value logic for the FSM and its datapath.
  always_comb begin
    state_s      = state_r;
    rr_ptr_s     = rr_ptr_r;
    xfer_id_s    = xfer_id_r;
    cnt_s        = cnt_r;
    clr_mask_s   = '0;
    tmo_set_s    = 1'b0;
    grant_done_s = '0;
    xfer_pulse_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sel_valid_s) begin
          clr_mask_s = N_REQ'(1'b1) << sel_idx_s;
          xfer_id_s  = ID_W'(sel_idx_s);
          rr_ptr_s   = (sel_idx_s == IDX_W'(N_REQ - 1)) ? '0 : sel_idx_s + IDX_W'(1);
          state_s    = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // The pulse is registered, so it is seen during the first WAIT_BUSY cycle.
        xfer_pulse_s = 1'b1;
        cnt_s        = '0;
        state_s      = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (xfer_busy) begin
          state_s = ST_WAIT_DONE;
        end else if (cnt_r >= CNT_W'(TIMEOUT - 1)) begin
          // Count reaches TIMEOUT on this edge and is held there.
          cnt_s     = CNT_W'(TIMEOUT);
          tmo_set_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!xfer_busy) begin
          grant_done_s = N_REQ'(1'b1) << xfer_id_r;
          state_s      = ST_IDLE;
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // A new request on the bit being selected survives the clear.
    pending_s  = (pending_r & ~clr_mask_s) | req_pulse;
    overflow_s = (req_pulse & pending_r & ~clr_mask_s) | (clr_err ? '0 : overflow_r);
    timeout_s  = tmo_set_s | (clr_err ? 1'b0 : timeout_r);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= '0;
      pending_r    <= '0;
      overflow_r   <= '0;
      timeout_r    <= 1'b0;
      cnt_r        <= '0;
      xfer_id_r    <= '0;
      xfer_pulse_r <= 1'b0;
      grant_done_r <= '0;
    end else begin
      state_r      <= state_s;
      rr_ptr_r     <= rr_ptr_s;
      pending_r    <= pending_s;
      overflow_r   <= overflow_s;
      timeout_r    <= timeout_s;
      cnt_r        <= cnt_s;
      xfer_id_r    <= xfer_id_s;
      xfer_pulse_r <= xfer_pulse_s;
      grant_done_r <= grant_done_s;
    end
  end

  assign xfer_pulse = xfer_pulse_r;
  assign xfer_id    = xfer_id_r;
  assign grant_done = grant_done_r;
  assign pending    = pending_r;
  assign overflow   = overflow_r;
  assign timeout    = timeout_r;

endmodule

// File: tb/tb_pulse_xfer_arbiter.sv
// Testbench for pulse_xfer_arbiter: directed stimulus feeds expected
// xfer_id / grant_done values into queues, a monitor pops and compares
// whenever the DUT pulses or grants. A responder models the channel busy flag.
module tb_pulse_xfer_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_pulse;
  logic       clr_err;
  logic       xfer_busy;
  logic       xfer_pulse;
  logic [1:0] xfer_id;
  logic [3:0] grant_done;
  logic [3:0] pending;
  logic [3:0] overflow;
  logic       timeout;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int pulse_cnt = 0;
  int grant_cnt = 0;
  bit busy_mode = 1'b1;
  bit in_flight = 1'b0;

  int         exp_id_q[$];
  logic [3:0] exp_grant_q[$];

  pulse_xfer_arbiter #(.N_REQ(4), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_pulse  (req_pulse),
    .clr_err    (clr_err),
    .xfer_busy  (xfer_busy),
    .xfer_pulse (xfer_pulse),
    .xfer_id    (xfer_id),
    .grant_done (grant_done),
    .pending    (pending),
    .overflow   (overflow),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel model: busy rises 2 cycles after a pulse and stays high 4 cycles.
  initial begin
    xfer_busy = 1'b0;
    forever begin
      tick();
      if (xfer_pulse && busy_mode) begin
        tick();
        tick();
        xfer_busy = 1'b1;
        repeat (4) tick();
        xfer_busy = 1'b0;
      end
    end
  end

  // Monitor: compare every pulse and grant against the scoreboard queues.
  initial begin
    int         e_id;
    logic [3:0] e_gr;
    forever begin
      @(negedge clk);
      if (!rst_n || timeout) in_flight = 1'b0;
      if (xfer_pulse) begin
        pulse_cnt++;
        check("pulse_while_in_flight", 32'(in_flight), 32'd0);
        in_flight = 1'b1;
        if (exp_id_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: got xfer_id %0d, none expected", xfer_id);
        end else begin
          e_id = exp_id_q.pop_front();
          check("xfer_id", 32'(xfer_id), 32'(e_id));
        end
      end
      if (grant_done != 4'b0000) begin
        grant_cnt++;
        in_flight = 1'b0;
        if (exp_grant_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_grant: got %b, none expected", grant_done);
        end else begin
          e_gr = exp_grant_q.pop_front();
          check("grant_done", 32'(grant_done), 32'(e_gr));
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_id_q.delete();
    exp_grant_q.delete();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_id_q.size() != 0 || exp_grant_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $display("FAIL %s_wait: got %0d ids / %0d grants outstanding, required 0", name,
               exp_id_q.size(), exp_grant_q.size());
      exp_id_q.delete();
      exp_grant_q.delete();
    end
    repeat (3) tick();
  endtask

  task automatic wait_pulse(input string name);
    int n;
    n = 0;
    while (!xfer_pulse && n < 40) begin
      tick();
      n++;
    end
    check({name, "_pulse_seen"}, 32'(xfer_pulse), 32'd1);
  endtask

  initial begin
    int p_cyc;
    int n;
    rst_n     = 1'b0;
    req_pulse = 4'b0000;
    clr_err   = 1'b0;

    // Reset state
    do_reset();
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_xfer_pulse", 32'(xfer_pulse), 32'h0);
    check("rst_grant_done", 32'(grant_done), 32'h0);
    check("rst_xfer_id", 32'(xfer_id), 32'h0);

    // Single request, latency t -> t+2
    exp_id_q.push_back(0);
    exp_grant_q.push_back(4'b0001);
    req_pulse = 4'b0001;
    tick();
    req_pulse = 4'b0000;
    check("single_pending", 32'(pending), 32'h1);
    tick();
    check("single_no_early_pulse", 32'(xfer_pulse), 32'd0);
    tick();
    check("single_pulse_t2", 32'(xfer_pulse), 32'd1);
    wait_idle("single");

    // Contention from rr_ptr 0: order 0,1,2,3
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_id_q.push_back(i);
      exp_grant_q.push_back(4'(1 << i));
    end
    req_pulse = 4'b1111;
    tick();
    req_pulse = 4'b0000;
    check("contend_pending", 32'(pending), 32'hF);
    wait_idle("contend");
    check("contend_overflow", 32'(overflow), 32'h0);

    // Fairness: rr_ptr 0, re-request of 1 on its selection edge -> 1,2,1
    exp_id_q.push_back(1);
    exp_grant_q.push_back(4'b0010);
    exp_id_q.push_back(2);
    exp_grant_q.push_back(4'b0100);
    exp_id_q.push_back(1);
    exp_grant_q.push_back(4'b0010);
    req_pulse = 4'b0110;
    tick();
    req_pulse = 4'b0010;
    tick();
    req_pulse = 4'b0000;
    check("fair_pending_kept", 32'(pending), 32'h6);
    check("fair_no_overflow", 32'(overflow), 32'h0);
    wait_idle("fair");

    // Timeout: busy never rises; rr_ptr 2 -> picks 0
    busy_mode = 1'b0;
    exp_id_q.push_back(0);
    req_pulse = 4'b0001;
    tick();
    req_pulse = 4'b0000;
    wait_pulse("tmo");
    p_cyc = cyc;
    n = 0;
    while (!timeout && n < 40) begin
      tick();
      n++;
    end
    check("tmo_flag", 32'(timeout), 32'd1);
    check("tmo_cycles", 32'(cyc - p_cyc), 32'd15);
    repeat (5) tick();
    check("tmo_sticky", 32'(timeout), 32'd1);
    check("tmo_pending", 32'(pending), 32'h0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("tmo_cleared", 32'(timeout), 32'd0);
    busy_mode = 1'b1;
    wait_idle("tmo");

    // Overflow: two requests from 3 while 0 in flight (rr_ptr 1 -> picks 0)
    exp_id_q.push_back(0);
    exp_grant_q.push_back(4'b0001);
    exp_id_q.push_back(3);
    exp_grant_q.push_back(4'b1000);
    req_pulse = 4'b0001;
    tick();
    req_pulse = 4'b0000;
    wait_pulse("ovf");
    req_pulse = 4'b1000;
    tick();
    req_pulse = 4'b0000;
    tick();
    req_pulse = 4'b1000;
    tick();
    req_pulse = 4'b0000;
    check("ovf_flag", 32'(overflow), 32'h8);
    check("ovf_pending", 32'(pending), 32'h8);
    wait_idle("ovf");
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'h0);

    // Reset during WAIT_DONE (rr_ptr 0, request 2 -> picks 2)
    exp_id_q.push_back(2);
    req_pulse = 4'b0100;
    tick();
    req_pulse = 4'b0000;
    wait_pulse("rstwd");
    tick();
    tick();
    tick();
    check("rstwd_busy_high", 32'(xfer_busy), 32'd1);
    rst_n     = 1'b0;
    req_pulse = 4'b0001;
    tick();
    rst_n     = 1'b1;
    req_pulse = 4'b0000;
    check("rstwd_pending", 32'(pending), 32'h0);
    check("rstwd_grant", 32'(grant_done), 32'h0);
    check("rstwd_xfer_id", 32'(xfer_id), 32'h0);
    check("rstwd_pulse", 32'(xfer_pulse), 32'h0);
    repeat (10) tick();
    check("rstwd_busy_fell", 32'(xfer_busy), 32'd0);

    check("total_pulses", 32'(pulse_cnt), 32'd12);
    check("total_grants", 32'(grant_cnt), 32'd10);
    check("id_queue_empty", 32'(exp_id_q.size()), 32'd0);
    check("grant_queue_empty", 32'(exp_grant_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pulse_xfer_arbiter.md
PULSE_XFER_ARBITER -- requirements
Module: pulse_xfer_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one clock-domain pulse-crossing channel.
REQ-002 Parameter TIMEOUT, default 15: max clk cycles to wait for xfer_busy rise after an issued pulse.
REQ-003 clk  input  1  single block clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_pulse  input  N_REQ  one-cycle transfer requests, one bit per requester.
REQ-006 clr_err  input  1  one-cycle clear of sticky overflow/timeout flags.
REQ-007 xfer_busy  input  1  crossing-channel in-flight flag (high while a pulse is crossing).
REQ-008 xfer_pulse  output  1  one-cycle pulse into the crossing channel source side.
REQ-009 xfer_id  output  2  index of requester currently served; stable from ISSUE until return to IDLE.
REQ-010 grant_done  output  N_REQ  one-cycle completion pulse for the served requester.
REQ-011 pending  output  N_REQ  registered pending-request bits.
REQ-012 overflow  output  N_REQ  sticky: request arrived while same bit already pending.
REQ-013 timeout  output  1  sticky: xfer_busy never rose within TIMEOUT cycles.

Function
REQ-014 FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE; all outputs registered or Moore-decoded from state.
REQ-015 req_pulse[i] sampled at edge t sets pending[i] visible after edge t.
REQ-016 IDLE: if any pending bit set, select by round-robin from pointer rr_ptr, latch xfer_id, clear that pending bit, go ISSUE; else stay.
REQ-017 Round-robin: search order rr_ptr, rr_ptr+1, ... mod N_REQ; after selecting i, rr_ptr = (i+1) mod N_REQ.
REQ-018 ISSUE: xfer_pulse = 1 for exactly this one cycle; next state WAIT_BUSY, timeout counter cleared to 0.
REQ-019 Latency: req_pulse sampled at edge t with FSM idle and no other pending -> xfer_pulse high in cycle after edge t+2.
REQ-020 WAIT_BUSY: xfer_busy = 1 -> WAIT_DONE; else counter increments; counter reaching TIMEOUT -> set timeout, go IDLE, no grant_done.
REQ-021 WAIT_DONE: xfer_busy = 0 -> grant_done[xfer_id] = 1 for one cycle, go IDLE; no timeout in this state.
REQ-022 Only one transfer in flight; xfer_pulse never asserts outside ISSUE.
REQ-023 Simultaneous req_pulse[i] and clearing of pending[i] by selection: pending[i] remains set (new request kept), no overflow.
REQ-024 req_pulse[i] while pending[i] = 1 and not being cleared: request merged, overflow[i] set.
REQ-025 clr_err clears overflow and timeout; a set event in the same cycle wins over clear.
REQ-026 Counter width ceil(log2(TIMEOUT+1)); no wrap, saturates at TIMEOUT.

Reset
REQ-027 rst_n = 0 at a rising edge: state IDLE, rr_ptr 0, pending 0, overflow 0, timeout 0, counter 0, xfer_id 0, xfer_pulse 0, grant_done 0.
REQ-028 Reset mid-transfer abandons it: no grant_done issued; requests sampled during reset are dropped.

Structure
REQ-029 Shared package holds FSM state encoding, N_REQ and TIMEOUT defaults, and the xfer_id width constant.
REQ-030 One sub-module rr_select (combinational round-robin pick: pending, rr_ptr -> valid, index); everything else in the top.

Verification
REQ-031 Single request: req_pulse=0001 at edge t, xfer_busy rises 2 cycles after xfer_pulse and stays high 4 cycles -> xfer_pulse at t+2, xfer_id=0, grant_done=0001 one cycle after busy falls.
REQ-032 Contention: req_pulse=1111 in one cycle -> service order 0,1,2,3; four xfer_pulse, each only after prior grant_done.
REQ-033 Fairness: requester 1 re-requests continuously, requester 2 once -> order 1,2,1, not 1,1.
REQ-034 Timeout: xfer_busy held 0 after xfer_pulse -> timeout=1 after 15 cycles, FSM IDLE, no grant_done; clr_err -> timeout=0.
REQ-035 Overflow: two req_pulse[3] while requester 0 in flight -> overflow=1000, single transfer for 3.
REQ-036 Reset in WAIT_DONE: rst_n=0 one cycle -> all outputs 0, no grant_done when busy later falls.
